usb_link_ctrl: RTL

Half-duplex link sequencer above usb_phy.
- Tracks RX packet boundaries from the PHY.
- Enforces the inter-packet gap before any TX.
- Arbitrates two TX requesters (0 = handshake responder, 1 = data sender) onto the PHY's single tx_data/tx_den stream.
- Times the response window after our own TX.
- Detects USB bus reset (long SE0).

---
 rtl/usb_link_pkg.sv | 39 +++
 rtl/usb_link_timer.sv | 48 ++++
 rtl/usb_link_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/usb_link_pkg.sv
// usb_link_pkg: shared definitions for the USB link sequencer.
//   - link_state_e : FSM state encoding (4 bits, same width as the PHY FSM)
//   - REQ_*        : requester indices on the req_*/gnt buses
//   - FS_/LS_*     : default cycle counts for full speed and low speed
//   - req_onehot() : converts a latched requester index to a grant vector
package usb_link_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_RX        = 4'd1,
    ST_GAP       = 4'd2,
    ST_TX_START  = 4'd3,
    ST_TX        = 4'd4,
    ST_WAIT_RESP = 4'd5,
    ST_BUS_RESET = 4'd6
  } link_state_e;

  localparam int unsigned REQ_HNDSHK = 0;
  localparam int unsigned REQ_DATA   = 1;

  // Full speed: 24 MHz clock, two clocks per bit time.
  localparam int unsigned FS_GAP_MIN_CYC      = 4;
  localparam int unsigned FS_RESP_TIMEOUT_CYC = 36;
  localparam int unsigned FS_RESET_SE0_CYC    = 60;
  localparam int unsigned FS_TX_START_TO_CYC  = 4;
  localparam int unsigned FS_CNT_WIDTH        = 8;

  // Low speed: bit times are eight times longer at the same clock.
  localparam int unsigned LS_GAP_MIN_CYC      = 8 * FS_GAP_MIN_CYC;
  localparam int unsigned LS_RESP_TIMEOUT_CYC = 8 * FS_RESP_TIMEOUT_CYC;
  localparam int unsigned LS_RESET_SE0_CYC    = 8 * FS_RESET_SE0_CYC;
  localparam int unsigned LS_TX_START_TO_CYC  = 8 * FS_TX_START_TO_CYC;
  localparam int unsigned LS_CNT_WIDTH        = 10;

  function automatic logic [1:0] req_onehot(input logic sel);
    return sel ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/usb_link_timer.sv
// usb_link_timer: loadable saturating up-counter with terminal compare.
//   clk_i, rst_ni : clock, synchronous active-low reset (loads RST_VAL)
//   clr_i         : force count to zero (highest priority)
//   load_i        : load load_val_i
//   en_i          : count up, stopping at sat_val_i
//   term_val_i    : compare value
//   term_o        : count has reached or passed term_val_i
module usb_link_timer
  import usb_link_pkg::*;
#(
  parameter int unsigned     WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic [WIDTH-1:0] sat_val_i,
  input  logic [WIDTH-1:0] term_val_i,
  output logic             term_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q < sat_val_i)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_o = (cnt_q >= term_val_i);

endmodule

// File: rtl/usb_link_ctrl.sv
// usb_link_ctrl: half-duplex link sequencer sitting above usb_phy.
//   phy_rx_packet_st_i/ed_i : SYNC / EOP pulses from the PHY receiver
//   phy_rx_se0_det_i        : line is SE0 (bus reset detection)
//   phy_tx_busy_i           : PHY transmitter active
//   phy_tx_data_o/den_o     : bit stream of the granted requester to the PHY
//   req_i, req_expect_resp_i, req_data_i, req_den_i : two TX requesters
//                             (0 = handshake responder, 1 = data sender)
//   gnt_o                   : one-hot grant, held for the whole transmission
//   rx_active_o, rx_done_o, tx_done_o, resp_timeout_o, tx_start_err_o,
//   bus_reset_o             : link status
module usb_link_ctrl
  import usb_link_pkg::*;
#(
  parameter int unsigned GAP_MIN_CYC      = FS_GAP_MIN_CYC,
  parameter int unsigned RESP_TIMEOUT_CYC = FS_RESP_TIMEOUT_CYC,
  parameter int unsigned RESET_SE0_CYC    = FS_RESET_SE0_CYC,
  parameter int unsigned TX_START_TO_CYC  = FS_TX_START_TO_CYC,
  parameter int unsigned CNT_WIDTH        = FS_CNT_WIDTH
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       phy_rx_packet_st_i,
  input  logic       phy_rx_packet_ed_i,
  input  logic       phy_rx_se0_det_i,
  input  logic       phy_tx_busy_i,
  output logic       phy_tx_data_o,
  output logic       phy_tx_den_o,
  input  logic [1:0] req_i,
  input  logic [1:0] req_expect_resp_i,
  input  logic [1:0] req_data_i,
  input  logic [1:0] req_den_i,
  output logic [1:0] gnt_o,
  output logic       rx_active_o,
  output logic       rx_done_o,
  output logic       tx_done_o,
  output logic       resp_timeout_o,
  output logic       tx_start_err_o,
  output logic       bus_reset_o
);

  localparam logic [CNT_WIDTH-1:0] GAP_MIN    = CNT_WIDTH'(GAP_MIN_CYC);
  localparam logic [CNT_WIDTH-1:0] GAP_TERM   = CNT_WIDTH'(GAP_MIN_CYC - 1);
  localparam logic [CNT_WIDTH-1:0] RESP_TERM  = CNT_WIDTH'(RESP_TIMEOUT_CYC - 1);
  localparam logic [CNT_WIDTH-1:0] START_TERM = CNT_WIDTH'(TX_START_TO_CYC - 1);
  localparam logic [CNT_WIDTH-1:0] SE0_SAT    = CNT_WIDTH'(RESET_SE0_CYC);
  localparam logic [CNT_WIDTH-1:0] SE0_TERM   = CNT_WIDTH'(RESET_SE0_CYC - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

  link_state_e state_q, state_d;
  logic        req_sel_q, req_sel_d;
  logic        exp_resp_q, exp_resp_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        rx_done_q, rx_done_d;
  logic        tx_done_q, tx_done_d;
  logic        resp_to_q, resp_to_d;
  logic        start_err_q, start_err_d;

  logic                 tmr_clr, tmr_load, tmr_en, tmr_term;
  logic [CNT_WIDTH-1:0] tmr_sat, tmr_term_val;
  logic                 se0_inc, se0_term, bus_qual;
  logic                 winner;

  // The gap timer is shared: gap in IDLE/GAP, start timeout in TX_START,
  // response window in WAIT_RESP. Its terminal value depends on state only,
  // which keeps it out of the next-state loop. The gap compare is one below
  // GAP_MIN so that the cycle in which the gap completes can already move to
  // TX_START; in IDLE the counter sits at GAP_MIN.
  always_comb begin
    tmr_term_val = GAP_TERM;
    tmr_sat      = GAP_MIN;
    case (state_q)
      ST_TX_START: begin
        tmr_term_val = START_TERM;
        tmr_sat      = CNT_MAX;
      end
      ST_WAIT_RESP: begin
        tmr_term_val = RESP_TERM;
        tmr_sat      = CNT_MAX;
      end
      default: ;
    endcase
  end

  usb_link_timer #(.WIDTH(CNT_WIDTH), .RST_VAL(GAP_MIN)) u_gap_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (tmr_clr),
    .load_i     (tmr_load),
    .en_i       (tmr_en),
    .load_val_i (GAP_MIN),
    .sat_val_i  (tmr_sat),
    .term_val_i (tmr_term_val),
    .term_o     (tmr_term)
  );

  // SE0 only counts while we are not driving the line ourselves. Qualification
  // fires in the cycle the count reaches RESET_SE0_CYC.
  assign se0_inc  = phy_rx_se0_det_i && !phy_tx_busy_i;
  assign bus_qual = se0_inc && se0_term;

  usb_link_timer #(.WIDTH(CNT_WIDTH), .RST_VAL('0)) u_se0_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (!se0_inc),
    .load_i     (1'b0),
    .en_i       (se0_inc),
    .load_val_i ('0),
    .sat_val_i  (SE0_SAT),
    .term_val_i (SE0_TERM),
    .term_o     (se0_term)
  );

  // Fixed priority: the handshake responder wins over the data sender.
  assign winner = !req_i[REQ_HNDSHK];

  always_comb begin
    state_d     = state_q;
    req_sel_d   = req_sel_q;
    exp_resp_d  = exp_resp_q;
    rx_done_d   = 1'b0;
    tx_done_d   = 1'b0;
    resp_to_d   = 1'b0;
    start_err_d = 1'b0;
    tmr_clr     = 1'b0;
    tmr_load    = 1'b0;
    tmr_en      = 1'b0;

    case (state_q)
      ST_IDLE, ST_GAP: begin
        tmr_en = (state_q == ST_GAP);
        if (phy_rx_packet_st_i) begin
          state_d = ST_RX;
        end else if ((|req_i) && tmr_term) begin
          state_d    = ST_TX_START;
          req_sel_d  = winner;
          exp_resp_d = req_expect_resp_i[winner];
          tmr_clr    = 1'b1;
        end
      end
      ST_RX: begin
        if (phy_rx_packet_ed_i) begin
          state_d   = ST_GAP;
          rx_done_d = 1'b1;
          tmr_clr   = 1'b1;
        end
      end
      ST_TX_START: begin
        tmr_en = 1'b1;
        if (phy_tx_busy_i) begin
          state_d = ST_TX;
        end else if (tmr_term) begin
          state_d     = ST_IDLE;
          start_err_d = 1'b1;
          tmr_load    = 1'b1;
        end
      end
      ST_TX: begin
        if (!phy_tx_busy_i) begin
          state_d   = exp_resp_q ? ST_WAIT_RESP : ST_GAP;
          tx_done_d = 1'b1;
          tmr_clr   = 1'b1;
        end
      end
      ST_WAIT_RESP: begin
        tmr_en = 1'b1;
        if (phy_rx_packet_st_i) begin
          state_d = ST_RX;
        end else if (tmr_term) begin
          state_d   = ST_GAP;
          resp_to_d = 1'b1;
          tmr_load  = 1'b1;
        end
      end
      ST_BUS_RESET: begin
        if (!phy_rx_se0_det_i) begin
          state_d  = ST_IDLE;
          tmr_load = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Bus reset overrides whatever else happened this cycle.
    if (bus_qual && (state_q != ST_TX) && (state_q != ST_BUS_RESET)) begin
      state_d     = ST_BUS_RESET;
      req_sel_d   = 1'b0;
      exp_resp_d  = 1'b0;
      rx_done_d   = 1'b0;
      resp_to_d   = 1'b0;
      start_err_d = 1'b0;
      tmr_clr     = 1'b0;
      tmr_load    = 1'b0;
      tmr_en      = 1'b0;
    end

    gnt_d = ((state_d == ST_TX_START) || (state_d == ST_TX)) ? req_onehot(req_sel_d) : 2'b00;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      req_sel_q   <= 1'b0;
      exp_resp_q  <= 1'b0;
      gnt_q       <= 2'b00;
      rx_done_q   <= 1'b0;
      tx_done_q   <= 1'b0;
      resp_to_q   <= 1'b0;
      start_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_sel_q   <= req_sel_d;
      exp_resp_q  <= exp_resp_d;
      gnt_q       <= gnt_d;
      rx_done_q   <= rx_done_d;
      tx_done_q   <= tx_done_d;
      resp_to_q   <= resp_to_d;
      start_err_q <= start_err_d;
    end
  end

  // Grant is one-hot, so AND-OR selects the granted stream with no latency.
  assign phy_tx_data_o  = |(gnt_q & req_data_i);
  assign phy_tx_den_o   = |(gnt_q & req_den_i);
  assign gnt_o          = gnt_q;
  assign rx_active_o    = (state_q == ST_RX);
  assign bus_reset_o    = (state_q == ST_BUS_RESET);
  assign rx_done_o      = rx_done_q;
  assign tx_done_o      = tx_done_q;
  assign resp_timeout_o = resp_to_q;
  assign tx_start_err_o = start_err_q;

endmodule
